// File: rtl/gs_row_loader_if.sv
// Row-beat stream into the Gauss-Seidel row loader and the packed system
// buses it hands to the iteration cell.
interface gs_row_loader_if #(
  parameter int N   = 8,
  parameter int A_W = 8,
  parameter int R_W = 32,
  parameter int X_W = 32
);
  localparam int BEAT_W = (N - 1) * A_W + A_W + R_W + X_W;
  localparam int CNT_W  = $clog2(N);

  // Row stream: a beat moves on any rising edge where i_in_valid && o_in_ready.
  // The sender holds i_in_valid/i_in_data stable until that edge; o_in_ready
  // never looks at i_in_valid.
  logic                          i_in_valid;
  logic                          o_in_ready;
  logic [BEAT_W-1:0]             i_in_data;

  logic [N*(N-1)*A_W-1:0]        o_a;
  logic [N*R_W-1:0]              o_a_R;
  logic [N*A_W-1:0]              o_b;
  logic [N*X_W-1:0]              o_x;
  logic                          o_valid;
  logic                          i_done;
  logic                          o_busy;
  logic [CNT_W-1:0]              o_row_cnt;
  logic                          dbg_state;

  modport master (
    output i_in_valid, i_in_data, i_done,
    input  o_in_ready, o_a, o_a_R, o_b, o_x, o_valid, o_busy, o_row_cnt, dbg_state
  );

  modport slave (
    input  i_in_valid, i_in_data, i_done,
    output o_in_ready, o_a, o_a_R, o_b, o_x, o_valid, o_busy, o_row_cnt, dbg_state
  );
endinterface

// File: rtl/gs_row_loader.sv
// Double-buffered row loader: stages N row beats, then hands the packed system
// to the iteration cell with a one-cycle start strobe once its bank is free.
module gs_row_loader #(
  parameter int N   = 8,
  parameter int A_W = 8,
  parameter int R_W = 32,
  parameter int X_W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  gs_row_loader_if.slave bus
);
  localparam int ROW_A_W = (N - 1) * A_W;
  localparam int CNT_W   = $clog2(N);
  localparam int BEAT_W  = ROW_A_W + A_W + R_W + X_W;

  typedef enum logic {FREE = 1'b0, OWNED = 1'b1} state_t;

  state_t             state;
  logic [ROW_A_W-1:0] stg_a [N];
  logic [A_W-1:0]     stg_b [N];
  logic [R_W-1:0]     stg_r [N];
  logic [X_W-1:0]     stg_x [N];
  logic [CNT_W-1:0]   row_cnt;
  logic               staging_full;
  logic               done_low;
  logic               accept;
  logic               transfer;

  assign accept         = bus.i_in_valid && !staging_full;
  assign transfer       = staging_full && (state == FREE);
  assign bus.o_in_ready = !staging_full;
  assign bus.o_row_cnt  = row_cnt;
  assign bus.o_busy     = (state == OWNED);
  assign bus.dbg_state  = state;

  // Staging bank: rows land at row_cnt in arrival order; full blocks input
  // until the output bank takes the whole system.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      row_cnt      <= '0;
      staging_full <= 1'b0;
      for (int r = 0; r < N; r++) begin
        stg_a[r] <= '0;
        stg_b[r] <= '0;
        stg_r[r] <= '0;
        stg_x[r] <= '0;
      end
    end else if (transfer) begin
      staging_full <= 1'b0;
      row_cnt      <= '0;
    end else if (accept) begin
      stg_a[row_cnt] <= bus.i_in_data[BEAT_W-1 -: ROW_A_W];
      stg_b[row_cnt] <= bus.i_in_data[X_W+R_W+A_W-1 -: A_W];
      stg_r[row_cnt] <= bus.i_in_data[X_W+R_W-1 -: R_W];
      stg_x[row_cnt] <= bus.i_in_data[X_W-1:0];
      if (row_cnt == CNT_W'(N - 1)) begin
        staging_full <= 1'b1;
        row_cnt      <= '0;
      end else begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  // Output bank FSM. done_low arms the release so a done level left over from
  // the previous system cannot free the bank right after a new launch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= FREE;
      done_low    <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_a     <= '0;
      bus.o_a_R   <= '0;
      bus.o_b     <= '0;
      bus.o_x     <= '0;
    end else begin
      bus.o_valid <= 1'b0;
      case (state)
        FREE: begin
          if (transfer) begin
            for (int r = 0; r < N; r++) begin
              bus.o_a[(N-r)*ROW_A_W-1 -: ROW_A_W] <= stg_a[r];
              bus.o_a_R[(N-r)*R_W-1 -: R_W]       <= stg_r[r];
              bus.o_b[(N-r)*A_W-1 -: A_W]         <= stg_b[r];
              bus.o_x[(N-r)*X_W-1 -: X_W]         <= stg_x[r];
            end
            bus.o_valid <= 1'b1;
            done_low    <= 1'b0;
            state       <= OWNED;
          end
        end
        OWNED: begin
          if (!bus.i_done) begin
            done_low <= 1'b1;
          end else if (done_low) begin
            state <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_gs_row_loader.sv
// Bench for gs_row_loader: table-driven first load, hand-written corner
// sequences, and randomized gapped traffic checked against a system-level model.
module tb_gs_row_loader;
  localparam int N      = 8;
  localparam int BEAT_W = 128;
  localparam int OUT_W  = 448 + 256 + 64 + 256;

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic [2:0]        exp_cnt;
    logic              exp_ready;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  gs_row_loader_if bus ();

  gs_row_loader dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_valid  = 0;
  int                n_sys    = 0;
  logic [BEAT_W-1:0] beat_q[$];
  logic [OUT_W-1:0]  exp_q[$];
  logic [OUT_W-1:0]  held;
  logic [OUT_W-1:0]  exp_word;
  vec_t              tbl[N];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a system is N rows in arrival order; row 0 lands in the top slice
  // of every bus, so shifting each row in from the right yields the packing.
  function automatic logic [OUT_W-1:0] pack_rows();
    logic [447:0] a  = '0;
    logic [255:0] ar = '0;
    logic [63:0]  b  = '0;
    logic [255:0] x  = '0;
    for (int r = 0; r < N; r++) begin
      a  = (a  << 56) | 448'(beat_q[r][127:72]);
      ar = (ar << 32) | 256'(beat_q[r][63:32]);
      b  = (b  << 8)  | 64'(beat_q[r][71:64]);
      x  = (x  << 32) | 256'(beat_q[r][31:0]);
    end
    return {a, ar, b, x};
  endfunction

  function automatic logic [BEAT_W-1:0] row_beat(input int r);
    return {56'h01020304050607 + 56'(r), 8'(8'h10 + r), 32'hA000_0000 + 32'(r), 32'h100 + 32'(r)};
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Observe accepted beats; a reset discards anything not yet launched.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q.delete();
      exp_q.delete();
    end else if (bus.i_in_valid && bus.o_in_ready) begin
      beat_q.push_back(bus.i_in_data);
      if (beat_q.size() == N) begin
        exp_q.push_back(pack_rows());
        beat_q.delete();
        n_sys++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_o_valid: got strobe expected none at %0t", $time);
        end else begin
          exp_word = exp_q.pop_front();
          held     = exp_word;
          chk("launch_o_a",   512'(bus.o_a),   512'(exp_word[1023:576]));
          chk("launch_o_a_R", 512'(bus.o_a_R), 512'(exp_word[575:320]));
          chk("launch_o_b",   512'(bus.o_b),   512'(exp_word[319:256]));
          chk("launch_o_x",   512'(bus.o_x),   512'(exp_word[255:0]));
          chk("launch_busy",  512'(bus.o_busy), 512'(1));
        end
      end else if (bus.o_busy) begin
        chk("stable_o_a",   512'(bus.o_a),   512'(held[1023:576]));
        chk("stable_o_a_R", 512'(bus.o_a_R), 512'(held[575:320]));
        chk("stable_o_b",   512'(bus.o_b),   512'(held[319:256]));
        chk("stable_o_x",   512'(bus.o_x),   512'(held[255:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // exp_cnt < 0 skips the row-count check after acceptance.
  task automatic send_beat(input logic [BEAT_W-1:0] d, input int exp_cnt);
    int t = 0;
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = d;
    while (!bus.o_in_ready && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_checks++;
    if (t >= 400) begin
      n_fail++;
      $display("FAIL send_timeout: got no ready after %0d cycles expected ready at %0t", t, $time);
      bus.i_in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.i_in_valid = 1'b0;
      if (exp_cnt >= 0) chk("row_cnt", 512'(bus.o_row_cnt), 512'(exp_cnt));
    end
  endtask

  task automatic pulse_done();
    bus.i_done = 1'b1;
    idle(2);
    bus.i_done = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_o_a"},     512'(bus.o_a),       512'(0));
    chk({tag, "_o_a_R"},   512'(bus.o_a_R),     512'(0));
    chk({tag, "_o_b"},     512'(bus.o_b),       512'(0));
    chk({tag, "_o_x"},     512'(bus.o_x),       512'(0));
    chk({tag, "_valid"},   512'(bus.o_valid),   512'(0));
    chk({tag, "_busy"},    512'(bus.o_busy),    512'(0));
    chk({tag, "_state"},   512'(bus.dbg_state), 512'(0));
    chk({tag, "_row_cnt"}, 512'(bus.o_row_cnt), 512'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int snap;
    int target;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = '0;
    bus.i_done     = 1'b0;
    rst            = 1'b1;

    for (int r = 0; r < N; r++) begin
      tbl[r].data      = row_beat(r);
      tbl[r].exp_cnt   = 3'((r + 1) % N);
      tbl[r].exp_ready = (r != N - 1);
    end

    idle(3);
    rst = 1'b0;
    #1;
    check_cleared("reset");
    chk("reset_ready", 512'(bus.o_in_ready), 512'(1));

    // Single load, back-to-back, table driven.
    for (int r = 0; r < N; r++) begin
      send_beat(tbl[r].data, -1);
      chk("tbl_row_cnt", 512'(bus.o_row_cnt),  512'(tbl[r].exp_cnt));
      chk("tbl_ready",   512'(bus.o_in_ready), 512'(tbl[r].exp_ready));
    end
    chk("no_valid_first_edge", 512'(bus.o_valid), 512'(0));
    idle(1);
    chk("valid_second_edge", 512'(bus.o_valid),        512'(1));
    chk("busy_after_launch", 512'(bus.o_busy),         512'(1));
    chk("ready_after_launch", 512'(bus.o_in_ready),    512'(1));
    chk("single_o_b",        512'(bus.o_b),            512'(64'h1011121314151617));
    chk("single_o_x_row0",   512'(bus.o_x[255:224]),   512'(32'h0000_0100));
    chk("single_o_a_R_row7", 512'(bus.o_a_R[31:0]),    512'(32'hA000_0007));
    chk("single_o_a_row0",   512'(bus.o_a[447:392]),   512'(56'h01020304050607));
    idle(1);
    chk("valid_one_cycle",   512'(bus.o_valid),        512'(0));

    // Overlap: next system loads while the cell owns the output bank.
    snap = n_valid;
    for (int k = 0; k < N; k++) send_beat(rand_beat(), (k + 1) % N);
    chk("overlap_ready_low", 512'(bus.o_in_ready), 512'(0));
    idle(6);
    chk("overlap_no_valid",  512'(n_valid),        512'(snap));
    chk("overlap_busy",      512'(bus.o_busy),     512'(1));
    bus.i_done = 1'b1;
    idle(1);
    chk("done_frees",        512'(bus.o_busy),     512'(0));
    chk("done_no_valid_yet", 512'(bus.o_valid),    512'(0));
    idle(1);
    chk("overlap_launch",    512'(bus.o_valid),    512'(1));
    chk("overlap_ready_back", 512'(bus.o_in_ready), 512'(1));

    // Stale done: level still high across the new launch.
    idle(5);
    chk("stale_done_hold",   512'(bus.o_busy), 512'(1));
    bus.i_done = 1'b0;
    idle(1);
    chk("done_low_hold",     512'(bus.o_busy), 512'(1));
    bus.i_done = 1'b1;
    idle(1);
    chk("done_rise_frees",   512'(bus.o_busy), 512'(0));
    bus.i_done = 1'b0;
    idle(2);

    // Backpressure: continuous valid across a full staging bank.
    for (int k = 0; k < N; k++) send_beat(rand_beat(), (k + 1) % N);
    fork
      for (int k = 0; k < 2 * N; k++) send_beat(rand_beat(), ((k % N) + 1) % N);
      begin
        idle(30);
        pulse_done();
        idle(30);
        pulse_done();
      end
    join
    idle(4);
    chk("bp_busy", 512'(bus.o_busy), 512'(1));

    // Reset mid-load while the bank is owned.
    for (int k = 0; k < 5; k++) send_beat(rand_beat(), k + 1);
    rst = 1'b1;
    #1;
    check_cleared("midreset");
    idle(2);
    rst = 1'b0;
    #1;
    chk("midreset_ready", 512'(bus.o_in_ready), 512'(1));
    for (int k = 0; k < N; k++) send_beat(rand_beat(), (k + 1) % N);
    idle(3);
    chk("post_reset_busy", 512'(bus.o_busy), 512'(1));
    pulse_done();
    idle(2);

    // Gapped random traffic with a random done responder.
    target = n_valid + 3;
    fork
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < N; k++) begin
          idle($urandom_range(0, 1));
          send_beat(rand_beat(), (k + 1) % N);
        end
      end
      begin
        int t = 0;
        while (n_valid < target && t < 300) begin
          idle($urandom_range(3, 10));
          bus.i_done = 1'b1;
          idle($urandom_range(1, 2));
          bus.i_done = 1'b0;
          t++;
        end
      end
    join
    idle(5);

    chk("exp_q_drained", 512'(exp_q.size()), 512'(0));
    chk("launch_count",  512'(n_valid),      512'(n_sys));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
